// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control unit.
//   - FSM state encoding (state_t), visible on the state output port
//   - mux/operation codes for NPCOp, ALUOp, EXTOp, GPRSel and WDSel
//   - opcode (IR[31:26]) and funct (IR[5:0]) constants
//   - bit positions of the instruction-class one-hot produced by mc_decode
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MW    = 4'd4,
    S_WBM   = 4'd5,
    S_EXE   = 4'd6,
    S_WBA   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  // next-PC source
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // ALU operation
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  // immediate extension
  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // register-file write address
  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;
  localparam logic [1:0] GPR_RA = 2'b10;

  // register-file write data
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // opcodes
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;

  // funct codes (op = OP_R)
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // instruction-class one-hot bit positions; all-zero means illegal
  localparam int C_LW   = 0;
  localparam int C_SW   = 1;
  localparam int C_ADDU = 2;
  localparam int C_SUBU = 3;
  localparam int C_SLT  = 4;
  localparam int C_ORI  = 5;
  localparam int C_LUI  = 6;
  localparam int C_BEQ  = 7;
  localparam int C_J    = 8;
  localparam int C_JAL  = 9;
  localparam int C_JR   = 10;
  localparam int NCLS   = 11;

  typedef logic [NCLS-1:0] cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the control unit and the datapath.
//   datapath -> control : op, funct, zero
//   control -> datapath : PCWr, IRWr, RFWr, DMWr, NPCOp, ALUOp, EXTOp,
//                         GPRSel, WDSel, BSel
//   status              : state, retire, illegal
// master = control unit side, slave = datapath side.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic [1:0] NPCOp;
  logic [2:0] ALUOp;
  logic [1:0] EXTOp;
  logic [1:0] GPRSel;
  logic [1:0] WDSel;
  logic       BSel;
  logic [3:0] state;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output PCWr, IRWr, RFWr, DMWr, NPCOp, ALUOp, EXTOp, GPRSel, WDSel, BSel,
    output state, retire, illegal
  );

  modport slave (
    output op, funct, zero,
    input  PCWr, IRWr, RFWr, DMWr, NPCOp, ALUOp, EXTOp, GPRSel, WDSel, BSel,
    input  state, retire, illegal
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction classifier.
//   op    in  6   IR[31:26]
//   funct in  6   IR[5:0], only meaningful when op = R-type
//   cls   out 11  one-hot instruction class (bit positions in mc_pkg);
//                 all zeros for an unknown op/funct combination
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_R: begin
        case (funct)
          FN_ADDU: cls[C_ADDU] = 1'b1;
          FN_SUBU: cls[C_SUBU] = 1'b1;
          FN_SLT:  cls[C_SLT]  = 1'b1;
          FN_JR:   cls[C_JR]   = 1'b1;
          default: cls = '0;
        endcase
      end
      OP_LW:   cls[C_LW]  = 1'b1;
      OP_SW:   cls[C_SW]  = 1'b1;
      OP_BEQ:  cls[C_BEQ] = 1'b1;
      OP_J:    cls[C_J]   = 1'b1;
      OP_JAL:  cls[C_JAL] = 1'b1;
      OP_ORI:  cls[C_ORI] = 1'b1;
      OP_LUI:  cls[C_LUI] = 1'b1;
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: 10-state multicycle MIPS control FSM.
//   clock  in  1  rising-edge clock
//   reset  in  1  asynchronous active-high reset to FETCH
//   bus    mc_ctrl_if.master: op/funct/zero in; write enables, mux selects,
//          state, retire and illegal out.
// Parameter TRAP_ILLEGAL: 1 = unknown instruction pulses illegal in DCD and
// retires nothing; 0 = unknown instruction behaves as a nop retired in DCD.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic       clock,
  input  logic       reset,
  mc_ctrl_if.master  bus
);

  state_t state_reg, state_next;
  cls_t   cls;

  logic       pc_wr, ir_wr, rf_wr, dm_wr;
  logic       retire_raw, illegal_raw;
  logic [1:0] npc_op, ext_op, gpr_sel, wd_sel;
  logic [2:0] alu_op;
  logic       b_sel;

  logic [2:0] exe_alu_op;
  logic [1:0] exe_ext_op;
  logic       exe_b_sel;

  logic is_mem, is_r_alu, is_i_alu, is_exe, is_jump, is_illegal;

  mc_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls)
  );

  assign is_mem     = cls[C_LW] | cls[C_SW];
  assign is_r_alu   = cls[C_ADDU] | cls[C_SUBU] | cls[C_SLT];
  assign is_i_alu   = cls[C_ORI] | cls[C_LUI];
  assign is_exe     = is_r_alu | is_i_alu;
  assign is_jump    = cls[C_J] | cls[C_JAL] | cls[C_JR];
  assign is_illegal = ~|cls;

  // ALU controls shared by EXE and WBA; op/funct stay stable across both,
  // so WBA holds the EXE values without any extra register.
  always_comb begin
    exe_alu_op = ALU_ADD;
    exe_ext_op = EXT_ZERO;
    exe_b_sel  = 1'b0;
    if (cls[C_SUBU]) begin
      exe_alu_op = ALU_SUB;
    end else if (cls[C_SLT]) begin
      exe_alu_op = ALU_SLT;
    end else if (cls[C_ORI]) begin
      exe_alu_op = ALU_OR;
      exe_ext_op = EXT_ZERO;
      exe_b_sel  = 1'b1;
    end else if (cls[C_LUI]) begin
      exe_alu_op = ALU_LUI;
      exe_ext_op = EXT_UPPER;
      exe_b_sel  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = S_FETCH;
    pc_wr       = 1'b0;
    ir_wr       = 1'b0;
    rf_wr       = 1'b0;
    dm_wr       = 1'b0;
    npc_op      = NPC_PC4;
    alu_op      = ALU_ADD;
    ext_op      = EXT_ZERO;
    gpr_sel     = GPR_RD;
    wd_sel      = WD_ALU;
    b_sel       = 1'b0;
    retire_raw  = 1'b0;
    illegal_raw = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_wr      = 1'b1;
        pc_wr      = 1'b1;
        npc_op     = NPC_PC4;
        state_next = S_DCD;
      end
      S_DCD: begin
        if (is_mem) begin
          state_next = S_MA;
        end else if (is_exe) begin
          state_next = S_EXE;
        end else if (cls[C_BEQ]) begin
          state_next = S_BR;
        end else if (is_jump) begin
          state_next = S_JMP;
        end else begin
          state_next = S_FETCH;
          if (TRAP_ILLEGAL != 0) begin
            illegal_raw = is_illegal;
          end else begin
            retire_raw = is_illegal;
          end
        end
      end
      S_MA: begin
        alu_op     = ALU_ADD;
        b_sel      = 1'b1;
        ext_op     = EXT_SIGN;
        state_next = cls[C_LW] ? S_MR : S_MW;
      end
      S_MR: begin
        state_next = S_WBM;
      end
      S_MW: begin
        dm_wr      = 1'b1;
        retire_raw = 1'b1;
        state_next = S_FETCH;
      end
      S_WBM: begin
        rf_wr      = 1'b1;
        gpr_sel    = GPR_RT;
        wd_sel     = WD_DM;
        retire_raw = 1'b1;
        state_next = S_FETCH;
      end
      S_EXE: begin
        alu_op     = exe_alu_op;
        ext_op     = exe_ext_op;
        b_sel      = exe_b_sel;
        state_next = S_WBA;
      end
      S_WBA: begin
        alu_op     = exe_alu_op;
        ext_op     = exe_ext_op;
        b_sel      = exe_b_sel;
        rf_wr      = 1'b1;
        wd_sel     = WD_ALU;
        gpr_sel    = is_r_alu ? GPR_RD : GPR_RT;
        retire_raw = 1'b1;
        state_next = S_FETCH;
      end
      S_BR: begin
        alu_op     = ALU_SUB;
        b_sel      = 1'b0;
        npc_op     = NPC_BR;
        pc_wr      = bus.zero;   // Mealy: branch taken only when ALU says equal
        retire_raw = 1'b1;
        state_next = S_FETCH;
      end
      S_JMP: begin
        pc_wr      = 1'b1;
        npc_op     = cls[C_JR] ? NPC_JR : NPC_J;
        if (cls[C_JAL]) begin
          // PC was already advanced in FETCH, so WD=PC writes the link value
          rf_wr   = 1'b1;
          gpr_sel = GPR_RA;
          wd_sel  = WD_PC;
        end
        retire_raw = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Reset forces FETCH, but FETCH itself asserts PCWr/IRWr; mask every
  // write enable and pulse while reset is high so no write hits that edge.
  assign bus.PCWr    = pc_wr & ~reset;
  assign bus.IRWr    = ir_wr & ~reset;
  assign bus.RFWr    = rf_wr & ~reset;
  assign bus.DMWr    = dm_wr & ~reset;
  assign bus.retire  = retire_raw & ~reset;
  assign bus.illegal = illegal_raw & ~reset;

  assign bus.NPCOp  = npc_op;
  assign bus.ALUOp  = alu_op;
  assign bus.EXTOp  = ext_op;
  assign bus.GPRSel = gpr_sel;
  assign bus.WDSel  = wd_sel;
  assign bus.BSel   = b_sel;
  assign bus.state  = state_reg;

endmodule
